// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-stage definitions: FSM/PC-select encodings, reset PC, instruction width,
// and the base opcode constants used across the front end.
package ifu_fetch_pkg;

    localparam int unsigned INST_W           = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAddr = 2'd1,
        StData = 2'd2,
        StHold = 2'd3
    } fetch_state_e;

    typedef enum logic [1:0] {
        PcHold     = 2'd0,
        PcInc      = 2'd1,
        PcRedirect = 2'd2
    } pc_sel_e;

endpackage

// File: rtl/ifu_fetch_if.sv
// Fetch-stage bus: redirect/stall inputs, imem read channel and decode handshake.
// master = the fetch stage, slave = its environment (execute, memory, decode).
interface ifu_fetch_if import ifu_fetch_pkg::*; #(
    parameter int unsigned XLEN = 32
) ();

    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic              pipe_stop;

    logic [XLEN-1:0]   imem_araddr;
    logic              imem_arvalid;
    logic              imem_arready;
    logic [INST_W-1:0] imem_rdata;
    logic              imem_rvalid;
    logic              imem_rready;

    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
    logic              valid_next;
    logic              ready_next;

    modport master (
        input  redirect_valid, redirect_pc, pipe_stop,
        output imem_araddr, imem_arvalid,
        input  imem_arready, imem_rdata, imem_rvalid,
        output imem_rready,
        output inst, pc, valid_next,
        input  ready_next
    );

    modport slave (
        output redirect_valid, redirect_pc, pipe_stop,
        input  imem_araddr, imem_arvalid,
        output imem_arready, imem_rdata, imem_rvalid,
        input  imem_rready,
        input  inst, pc, valid_next,
        output ready_next
    );

endinterface

// File: rtl/ifu_pc_gen.sv
// Architectural fetch PC register: holds, steps by 4 (wrapping), or loads a redirect target.
module ifu_pc_gen import ifu_fetch_pkg::*; #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  pc_sel_e         pc_sel,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] pc_q, pc_d;

    always_comb begin
        pc_d = pc_q;
        case (pc_sel)
            PcInc:      pc_d = pc_q + XLEN'(4);
            PcRedirect: pc_d = redirect_pc;
            default:    pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign fetch_pc = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: one outstanding imem read, decode handshake, redirect squash.
// Optional IFU_PERF_CNT_EN adds perf_fetch_cnt / perf_stall_cnt outputs.
module ifu_fetch import ifu_fetch_pkg::*; #(
    parameter int unsigned      XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef IFU_PERF_CNT_EN
    ifu_fetch_if.master bus,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`else
    ifu_fetch_if.master bus
`endif
);

    fetch_state_e      state_q, state_d;
    logic              drop_q, drop_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic [XLEN-1:0]   out_pc_q, out_pc_d;
    logic [XLEN-1:0]   fetch_pc;
    pc_sel_e           pc_sel;
    logic              dec_fire;

    ifu_pc_gen #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_gen (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_sel      (pc_sel),
        .redirect_pc (bus.redirect_pc),
        .fetch_pc    (fetch_pc)
    );

    assign dec_fire = (state_q == StHold) && bus.ready_next && !bus.pipe_stop;

    always_comb begin
        state_d  = state_q;
        drop_d   = drop_q;
        inst_d   = inst_q;
        out_pc_d = out_pc_q;
        pc_sel   = bus.redirect_valid ? PcRedirect : PcHold;

        case (state_q)
            StIdle: state_d = StAddr;
            StAddr: begin
                // Address accepted in the redirect cycle is still outstanding: drop its data.
                if (bus.imem_arready) begin
                    state_d = StData;
                    drop_d  = bus.redirect_valid;
                end
            end
            StData: begin
                if (bus.imem_rvalid) begin
                    drop_d = 1'b0;
                    if (!bus.redirect_valid && !drop_q) begin
                        inst_d   = bus.imem_rdata;
                        out_pc_d = fetch_pc;
                        state_d  = StHold;
                    end else begin
                        state_d = StAddr;
                    end
                end else if (bus.redirect_valid) begin
                    drop_d = 1'b1;
                end
            end
            StHold: begin
                if (bus.redirect_valid) begin
                    state_d = StAddr;
                end else if (dec_fire) begin
                    pc_sel  = PcInc;
                    state_d = StAddr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            drop_q   <= 1'b0;
            inst_q   <= '0;
            out_pc_q <= '0;
        end else begin
            state_q  <= state_d;
            drop_q   <= drop_d;
            inst_q   <= inst_d;
            out_pc_q <= out_pc_d;
        end
    end

    assign bus.imem_arvalid = (state_q == StAddr);
    assign bus.imem_araddr  = fetch_pc;
    assign bus.imem_rready  = (state_q == StData);
    assign bus.valid_next   = (state_q == StHold);
    assign bus.inst         = inst_q;
    assign bus.pc           = out_pc_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (dec_fire) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (bus.valid_next && !dec_fire) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: imem responder + decode monitor feeding two scoreboards.
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    localparam int unsigned XLEN = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    ifu_fetch_if #(.XLEN(XLEN)) bus ();

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
    ifu_fetch #(.XLEN(XLEN), .RESET_PC(32'h8000_0000)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`else
    ifu_fetch #(.XLEN(XLEN), .RESET_PC(32'h8000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int hs_cnt  = 0;
    int rdelay  = 0;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_pc_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'h0013_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_hs(input int target);
        for (int i = 0; i < 200 && hs_cnt < target; i++) tick();
        check("hs_count", 32'(hs_cnt), 32'(target));
    endtask

    task automatic wait_valid();
        for (int i = 0; i < 200 && bus.valid_next !== 1'b1; i++) tick();
        check_bit("valid_wait", bus.valid_next, 1'b1);
    endtask

    // Memory: arready always high; data returns rdelay cycles after the address handshake.
    initial begin
        logic        ar_fire, r_fire;
        logic [31:0] ar_addr, pend_addr;
        int          cnt;
        ar_fire = 1'b0;
        r_fire = 1'b0;
        ar_addr = '0;
        pend_addr = '0;
        cnt = -1;
        bus.imem_arready = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = '0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                ar_fire = 1'b0;
                r_fire = 1'b0;
                cnt = -1;
                bus.imem_rvalid = 1'b0;
                bus.imem_rdata = '0;
            end else begin
                if (r_fire) begin
                    bus.imem_rvalid = 1'b0;
                    bus.imem_rdata = '0;
                end
                if (ar_fire) begin
                    pend_addr = ar_addr;
                    cnt = rdelay;
                end
                if (cnt == 0) begin
                    bus.imem_rvalid = 1'b1;
                    bus.imem_rdata = mem_word(pend_addr);
                    cnt = -1;
                end else if (cnt > 0) begin
                    cnt--;
                end
                ar_fire = bus.imem_arvalid && bus.imem_arready;
                ar_addr = bus.imem_araddr;
                r_fire = bus.imem_rvalid && bus.imem_rready;
                if (ar_fire) begin
                    check_bit("araddr_sb_nonempty", exp_addr_q.size() != 0, 1'b1);
                    if (exp_addr_q.size() != 0) check("araddr", ar_addr, exp_addr_q.pop_front());
                end
            end
        end
    end

    // Decode side: a handshake that will complete at the next edge pops the pc scoreboard.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && bus.valid_next && bus.ready_next && !bus.pipe_stop &&
                !bus.redirect_valid) begin
                hs_cnt++;
                check_bit("dec_sb_nonempty", exp_pc_q.size() != 0, 1'b1);
                if (exp_pc_q.size() != 0) begin
                    e = exp_pc_q.pop_front();
                    check("dec_pc", bus.pc, e);
                    check("dec_inst", bus.inst, mem_word(e));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, n_fail=%0d", n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        rst_n = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        bus.pipe_stop = 1'b0;
        bus.ready_next = 1'b0;
        repeat (3) tick();

        check_bit("rst_arvalid", bus.imem_arvalid, 1'b0);
        check_bit("rst_rready", bus.imem_rready, 1'b0);
        check_bit("rst_valid", bus.valid_next, 1'b0);
        check("rst_inst", bus.inst, 32'h0);
        check("rst_pc", bus.pc, 32'h0);
        check("rst_araddr", bus.imem_araddr, 32'h8000_0000);

        // Streaming fetch, decode always ready.
        exp_addr_q.push_back(32'h8000_0000);
        exp_addr_q.push_back(32'h8000_0004);
        exp_addr_q.push_back(32'h8000_0008);
        exp_addr_q.push_back(32'h8000_000C);
        exp_pc_q.push_back(32'h8000_0000);
        exp_pc_q.push_back(32'h8000_0004);
        exp_pc_q.push_back(32'h8000_0008);
        bus.ready_next = 1'b1;
        rst_n = 1'b1;
        check_bit("idle_arvalid", bus.imem_arvalid, 1'b0);
        tick();
        check_bit("first_arvalid", bus.imem_arvalid, 1'b1);
        check("first_araddr", bus.imem_araddr, 32'h8000_0000);
        wait_hs(3);
        bus.ready_next = 1'b0;

        // Decode stalls 5 cycles in HOLD.
        wait_valid();
        check("hold_pc", bus.pc, 32'h8000_000C);
        rdelay = 3;
        exp_addr_q.push_back(32'h8000_0010);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_bit("stall_valid", bus.valid_next, 1'b1);
            check("stall_pc", bus.pc, 32'h8000_000C);
            check("stall_inst", bus.inst, mem_word(32'h8000_000C));
            check_bit("stall_no_ar", bus.imem_arvalid, 1'b0);
        end
        exp_pc_q.push_back(32'h8000_000C);
        bus.ready_next = 1'b1;
        wait_hs(4);
        bus.ready_next = 1'b0;

        // Redirect while waiting for slow data: the 8000_0010 response is dropped.
        for (int i = 0; i < 50 && bus.imem_rready !== 1'b1; i++) tick();
        check_bit("data_wait", bus.imem_rready, 1'b1);
        exp_addr_q.push_back(32'h8000_0100);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0100;
        tick();
        bus.redirect_valid = 1'b0;
        rdelay = 0;
        check_bit("drop_rready", bus.imem_rready, 1'b1);
        check_bit("drop_no_ar", bus.imem_arvalid, 1'b0);
        check_bit("drop_valid", bus.valid_next, 1'b0);
        wait_valid();
        check("redir_pc", bus.pc, 32'h8000_0100);
        check("redir_inst", bus.inst, mem_word(32'h8000_0100));

        // Redirect in HOLD coinciding with ready_next: no +4, handshake void.
        exp_addr_q.push_back(32'h8000_0200);
        base = hs_cnt;
        bus.ready_next = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'h8000_0200;
        tick();
        bus.redirect_valid = 1'b0;
        bus.ready_next = 1'b0;
        check("hold_redir_araddr", bus.imem_araddr, 32'h8000_0200);
        check_bit("hold_redir_arvalid", bus.imem_arvalid, 1'b1);
        check_bit("hold_redir_valid0", bus.valid_next, 1'b0);
        tick();
        check_bit("hold_redir_valid1", bus.valid_next, 1'b0);
        check("hold_redir_no_hs", 32'(hs_cnt), 32'(base));

        // pipe_stop freezes HOLD; a redirect still wins. Then wrap FFFF_FFFC -> 0.
        wait_valid();
        check("ps_pc", bus.pc, 32'h8000_0200);
        bus.pipe_stop = 1'b1;
        bus.ready_next = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_bit("ps_valid", bus.valid_next, 1'b1);
            check("ps_pc_held", bus.pc, 32'h8000_0200);
            check_bit("ps_no_ar", bus.imem_arvalid, 1'b0);
        end
        exp_addr_q.push_back(32'hFFFF_FFFC);
        exp_addr_q.push_back(32'h0000_0000);
        exp_addr_q.push_back(32'h0000_0004);
        exp_pc_q.push_back(32'hFFFF_FFFC);
        exp_pc_q.push_back(32'h0000_0000);
        base = hs_cnt;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect_valid = 1'b0;
        bus.pipe_stop = 1'b0;
        check_bit("ps_redir_valid", bus.valid_next, 1'b0);
        check("ps_redir_araddr", bus.imem_araddr, 32'hFFFF_FFFC);
        wait_hs(base + 2);
        bus.ready_next = 1'b0;
        wait_valid();
        check("wrap_pc", bus.pc, 32'h0000_0004);

        // Synchronous reset from HOLD.
        rst_n = 1'b0;
        tick();
        check_bit("rst2_valid", bus.valid_next, 1'b0);
        check_bit("rst2_arvalid", bus.imem_arvalid, 1'b0);
        check("rst2_pc", bus.pc, 32'h0);
        check("rst2_inst", bus.inst, 32'h0);
        exp_addr_q.push_back(32'h8000_0000);
`ifdef IFU_PERF_CNT_EN
        check("perf_rst_fetch", perf_fetch_cnt, 32'd0);
        check("perf_rst_stall", perf_stall_cnt, 32'd0);
        exp_addr_q.push_back(32'h8000_0004);
        exp_addr_q.push_back(32'h8000_0008);
        exp_addr_q.push_back(32'h8000_000C);
        exp_pc_q.push_back(32'h8000_0000);
        exp_pc_q.push_back(32'h8000_0004);
        exp_pc_q.push_back(32'h8000_0008);
        base = hs_cnt;
        bus.ready_next = 1'b1;
        rst_n = 1'b1;
        wait_hs(base + 3);
        bus.ready_next = 1'b0;
        wait_valid();
        repeat (5) tick();
        check("perf_fetch", perf_fetch_cnt, 32'd3);
        check("perf_stall", perf_stall_cnt, 32'd5);
`else
        rst_n = 1'b1;
        tick();
        check_bit("rst2_first_arvalid", bus.imem_arvalid, 1'b1);
        check("rst2_first_araddr", bus.imem_araddr, 32'h8000_0000);
        wait_valid();
        check("rst2_fetch_pc", bus.pc, 32'h8000_0000);
`endif

        check("addr_sb_empty", 32'(exp_addr_q.size()), 32'd0);
        check("pc_sb_empty", 32'(exp_pc_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
